// File: rtl/dma_pkg.sv
// dma_pkg -- shared types and default constants for the DMA controller slice.
//   dma_state_t : controller FSM state encoding
//   DEF_*       : default memory geometry used by dma_ctrl and dma_addr_counter
package dma_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 192;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } dma_state_t;

endpackage

// File: rtl/dma_addr_counter.sv
// dma_addr_counter -- loadable address pointer with remaining-word count.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load i_base into the address and i_len into the count
//   i_base    : starting word address
//   i_len     : number of words
//   i_inc     : advance address by one (modulo 2^ADDR_W), count down by one
//   o_addr    : current word address
//   o_count   : words remaining
//   o_last    : current word is the final one
module dma_addr_counter
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_addr  <= i_base;
      r_count <= i_len;
    end else if (i_inc) begin
      r_addr  <= r_addr + ADDR_W'(1);
      r_count <= r_count - ADDR_W'(1);
    end
  end

  assign o_addr  = r_addr;
  assign o_count = r_count;
  assign o_last  = (r_count <= ADDR_W'(1));

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl -- single-channel word-copy DMA engine (read / wait / write per word).
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle request, accepted only in IDLE
//   src_addr    : first source word address
//   dst_addr    : first destination word address
//   len         : words to copy (0 = no transfer)
//   mem_wr      : memory write enable (0 = read)
//   mem_addr    : memory word address
//   mem_wdata   : write data (word buffer)
//   mem_rdata   : read data, valid one cycle after the read address
//   busy        : high in READ, WAIT, WRITE
//   done        : one-cycle completion pulse
//   err         : sticky completion status, cleared by an accepted start
//   words_left  : remaining word count
// Build option: DMA_CTRL_BOUND_CHECK_EN rejects transfers that run past DEPTH.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_left
);

`ifdef DMA_CTRL_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  dma_state_t        r_state;
  dma_state_t        w_next;
  logic [DATA_W-1:0] r_buf;
  logic              r_err;

  logic              w_load;
  logic              w_inc;
  logic              w_capture;
  logic              w_reject;
  logic [ADDR_W-1:0] w_load_len;
  logic [ADDR_W:0]   w_src_end;
  logic [ADDR_W:0]   w_dst_end;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic [ADDR_W-1:0] w_src_count;
  logic [ADDR_W-1:0] w_dst_count;
  logic              w_src_last;
  logic              w_dst_last;

  // src+len > DEPTH is the unwrapped form of src+len-1 > DEPTH-1.
  assign w_src_end  = {1'b0, src_addr} + {1'b0, len};
  assign w_dst_end  = {1'b0, dst_addr} + {1'b0, len};
  assign w_reject   = BOUND_CHECK && (len != '0) &&
                      ((w_src_end > (ADDR_W+1)'(DEPTH)) ||
                       (w_dst_end > (ADDR_W+1)'(DEPTH)));
  assign w_load_len = w_reject ? '0 : len;

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_src_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_base  (src_addr),
    .i_len   (w_load_len),
    .i_inc   (w_inc),
    .o_addr  (w_src_addr),
    .o_count (w_src_count),
    .o_last  (w_src_last)
  );

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_dst_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_base  (dst_addr),
    .i_len   (w_load_len),
    .i_inc   (w_inc),
    .o_addr  (w_dst_addr),
    .o_count (w_dst_count),
    .o_last  (w_dst_last)
  );

  // Both counters advance in lockstep, so their counts and last flags agree.
  assign words_left = (w_src_count > w_dst_count) ? w_src_count : w_dst_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_buf <= mem_rdata;
      if (w_load)    r_err <= w_reject;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    w_capture = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = ((len == '0) || w_reject) ? DONE : READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        mem_addr = w_src_addr;
        w_next   = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        mem_addr  = w_src_addr;
        w_capture = 1'b1;
        w_next    = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = w_dst_addr;
        w_inc    = 1'b1;
        w_next   = (w_src_last || w_dst_last) ? DONE : READ;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_wdata = r_buf;
  assign err       = r_err;

endmodule

// File: tb/tb_dma_ctrl.sv
module tb_dma_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr, len;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, err;
  logic [AW-1:0] words_left;

  always #5 clk = ~clk;

  dma_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(192)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_left (words_left)
  );

  // Synchronous memory: one-cycle read latency, preload port for the bench.
  logic [DW-1:0] mem [256];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_wr === 1'b1) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  logic [DW-1:0] shadow [256];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every bus write must match the next expected write.
  wr_t e;
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    shadow[a] = d;
  endtask

  task automatic expect_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l);
    logic [AW-1:0] as, ad;
    wr_t w;
    for (int i = 0; i < l; i++) begin
      as = s + AW'(i);
      ad = d + AW'(i);
      w.a = ad;
      w.d = shadow[as];
      shadow[ad] = shadow[as];
      q.push_back(w);
    end
  endtask

  task automatic run_xfer(input string name, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] l, input bit exp_err, input bit hiccup);
    int cyc, busy_n, exp_lat, exp_busy;
    bit seen;
    if (!exp_err) expect_copy(s, d, int'(l));
    exp_lat  = exp_err ? 1 : 3 * int'(l) + 1;
    exp_busy = exp_err ? 0 : 3 * int'(l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_n = 0; seen = 1'b0;
    while (cyc < 3 * 256 + 8) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_n++;
      if (hiccup && cyc == 4) begin
        start = 1'b1; src_addr = s + 8'd50; len = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_busy_cycles"}, busy_n, exp_busy);
    chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({name, "_words_left"}, {24'd0, words_left}, 32'd0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({name, "_queue_empty"}, q.size(), 32'd0);
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW-1:0] l;
    bit            hic;
  } vec_t;
  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    vt[0] = '{"basic3",    8'd1,   8'd10,  8'd3, 1'b0};
    vt[1] = '{"len0",      8'd40,  8'd60,  8'd0, 1'b0};
    vt[2] = '{"ovl_fwd",   8'd20,  8'd22,  8'd5, 1'b0};
    vt[3] = '{"ovl_back",  8'd100, 8'd98,  8'd4, 1'b0};
    vt[4] = '{"start_busy",8'd30,  8'd130, 8'd6, 1'b1};
    vt[5] = '{"short2",    8'd150, 8'd5,   8'd2, 1'b0};

    rst = 1'b1; start = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words_left", {24'd0, words_left}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    for (int a = 0; a < 256; a++) poke(AW'(a), 32'hC0DE_0000 + 32'(a) * 32'd257);
    poke(8'd1, 32'd8);
    poke(8'd2, 32'd9);
    poke(8'd3, 32'd12);
    @(negedge clk);
    pl_we = 1'b0;

    for (int i = 0; i < 6; i++) run_xfer(vt[i].name, vt[i].s, vt[i].d, vt[i].l, 1'b0, vt[i].hic);

    @(negedge clk);
    chk("basic3_mem10", mem[10], 32'd8);
    chk("basic3_mem11", mem[11], 32'd9);
    chk("basic3_mem12", mem[12], 32'd12);
    chk("ovl_fwd_mem26", mem[26], shadow[26]);
    chk("start_busy_mem135", mem[135], shadow[135]);

`ifdef DMA_CTRL_BOUND_CHECK_EN
    run_xfer("bound_err", 8'd190, 8'd0, 8'd4, 1'b1, 1'b0);
`else
    run_xfer("wrap", 8'd254, 8'd60, 8'd3, 1'b0, 1'b0);
    chk("wrap_mem62", mem[62], shadow[62]);
`endif

    // Abort during WAIT of word 2 of a 4-word transfer.
    expect_copy(8'd50, 8'd150, 1);
    @(negedge clk);
    src_addr = 8'd50; dst_addr = 8'd150; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_in_wait", {31'd0, busy}, 32'd1);
    chk("abort_wait_rd", {31'd0, mem_wr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_words_left", {24'd0, words_left}, 32'd0);
    chk("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    dn = 0;
    repeat (12) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", dn, 32'd0);
    chk("abort_queue_empty", q.size(), 32'd0);
    chk("abort_mem150", mem[150], shadow[150]);
    chk("abort_mem151", mem[151], shadow[151]);

    // Simultaneous reset and start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; src_addr = 8'd1; dst_addr = 8'd70; len = 8'd3;
    @(negedge clk);
    chk("rststart_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rststart_busy_after", {31'd0, busy}, 32'd0);
    chk("rststart_done", {31'd0, done}, 32'd0);
    chk("rststart_mem_wr", {31'd0, mem_wr}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rststart_queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
